// File: rtl/edge_detector_pkg.sv
// Shared constants, lane vector type and the per-bit edge equations for edge_detector.
// The falling-edge helper is only used when EDGE_DETECTOR_NEG_EDGE_EN is defined.
package edge_detector_pkg;

  localparam int EDGE_DET_DEFAULT_WIDTH = 8;

  typedef logic [EDGE_DET_DEFAULT_WIDTH-1:0] edge_det_vec_t;

  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic edge_fall(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/edge_detector_lane.sv
// One bit lane: previous-sample flop plus registered rising (and optional falling) pulse flops.
// Falling-edge output exists only when EDGE_DETECTOR_NEG_EDGE_EN is defined.
module edge_detector_lane
  import edge_detector_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic pedge_o
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
  ,
  output logic nedge_o
`endif
);

  logic prev_q;
  logic prev_d;
  logic pedge_q;
  logic pedge_d;
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
  logic nedge_q;
  logic nedge_d;
`endif

  // Next-state: compare the new sample against the one taken on the previous edge
  always_comb begin
    prev_d  = in_i;
    pedge_d = edge_rise(in_i, prev_q);
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
    nedge_d = edge_fall(in_i, prev_q);
`endif
  end

  // State update; reset wins over detection and makes the reset level count as 0
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      pedge_q <= 1'b0;
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
      nedge_q <= 1'b0;
`endif
    end else begin
      prev_q  <= prev_d;
      pedge_q <= pedge_d;
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
      nedge_q <= nedge_d;
`endif
    end
  end

  assign pedge_o = pedge_q;
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
  assign nedge_o = nedge_q;
`endif

endmodule

// File: rtl/edge_detector.sv
// Registered per-bit edge detector over WIDTH independent synchronous lanes.
// Define EDGE_DETECTOR_NEG_EDGE_EN to add the registered falling-edge output nedge.
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter int WIDTH = EDGE_DET_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] pedge
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
  ,
  output logic [WIDTH-1:0] nedge
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    edge_detector_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .in_i    (in[i]),
      .pedge_o (pedge[i])
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
      ,
      .nedge_o (nedge[i])
`endif
    );
  end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: directed vector table, then random input/reset traffic
// against a sample-history model. Checks nedge too when EDGE_DETECTOR_NEG_EDGE_EN is defined.
module tb_edge_detector;
  import edge_detector_pkg::*;

  typedef struct {
    logic          rst;
    edge_det_vec_t in;
    edge_det_vec_t exp_p;
    edge_det_vec_t exp_n;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_s = 1'b1;
  edge_det_vec_t in_s = 8'h00;
  edge_det_vec_t pedge_s;
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
  edge_det_vec_t nedge_s;
`endif

  int total = 0;
  int bad = 0;
  vec_t vecs[$];
  edge_det_vec_t hist[$];

  always #5 clk = ~clk;

  edge_detector #(.WIDTH(EDGE_DET_DEFAULT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset_s),
    .in    (in_s),
    .pedge (pedge_s)
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
    ,
    .nedge (nedge_s)
`endif
  );

  task automatic check(input string name, input int idx, input edge_det_vec_t act, input edge_det_vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input edge_det_vec_t i, input edge_det_vec_t p, input edge_det_vec_t n);
    vec_t v;
    v.rst = r; v.in = i; v.exp_p = p; v.exp_n = n;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, let one rising edge sample it, observe on the next falling edge
  task automatic step(input logic r, input edge_det_vec_t i);
    reset_s = r;
    in_s = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    edge_det_vec_t exp_p;
    edge_det_vec_t exp_n;
    logic r;
    edge_det_vec_t v;

    // reset, reset held with in=FF, release with in=FF
    add(1'b1, 8'h00, 8'h00, 8'h00);
    add(1'b1, 8'hFF, 8'h00, 8'h00);
    add(1'b0, 8'hFF, 8'hFF, 8'h00);
    add(1'b0, 8'hFF, 8'h00, 8'h00);
    add(1'b0, 8'h00, 8'h00, 8'hFF);
    add(1'b0, 8'h00, 8'h00, 8'h00);
    // single lane rising then held
    add(1'b0, 8'h02, 8'h02, 8'h00);
    add(1'b0, 8'h02, 8'h00, 8'h00);
    add(1'b0, 8'h02, 8'h00, 8'h00);
    add(1'b0, 8'h02, 8'h00, 8'h00);
    // extra lanes rise while bit 1 stays high
    add(1'b0, 8'h0E, 8'h0C, 8'h00);
    add(1'b0, 8'h0E, 8'h00, 8'h00);
    add(1'b0, 8'h0E, 8'h00, 8'h00);
    // falling lanes never pulse pedge
    add(1'b0, 8'h02, 8'h00, 8'h0C);
    add(1'b0, 8'h02, 8'h00, 8'h00);
    add(1'b0, 8'h02, 8'h00, 8'h00);
    add(1'b0, 8'h02, 8'h00, 8'h00);
    // alternating pattern
    add(1'b0, 8'h55, 8'h55, 8'h02);
    add(1'b0, 8'hAA, 8'hAA, 8'h55);
    add(1'b0, 8'h55, 8'h55, 8'hAA);
    add(1'b0, 8'hAA, 8'hAA, 8'h55);
    add(1'b0, 8'h00, 8'h00, 8'hAA);
    // reset on the 0->1 edge suppresses the pulse, next rise pulses normally
    add(1'b1, 8'h01, 8'h00, 8'h00);
    add(1'b0, 8'h00, 8'h00, 8'h00);
    add(1'b0, 8'h01, 8'h01, 8'h00);
    add(1'b0, 8'h00, 8'h00, 8'h01);
    // reset mid-pulse clears it on the same edge
    add(1'b0, 8'h04, 8'h04, 8'h00);
    add(1'b1, 8'h04, 8'h00, 8'h00);
    add(1'b0, 8'h04, 8'h04, 8'h00);
    add(1'b0, 8'h00, 8'h00, 8'h04);

    @(negedge clk);
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].in);
      check("pedge_vec", k, pedge_s, vecs[k].exp_p);
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
      check("nedge_vec", k, nedge_s, vecs[k].exp_n);
`endif
    end

    // Random traffic; the model keeps the history of samples seen since the last reset
    hist.delete();
    hist.push_back(8'h00);
    step(1'b1, 8'h00);
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 15) == 0);
      v = edge_det_vec_t'($urandom);
      if (($urandom_range(0, 3)) == 0) v = hist[$];
      step(r, v);
      if (r) begin
        hist.delete();
        hist.push_back(8'h00);
        exp_p = 8'h00;
        exp_n = 8'h00;
      end else begin
        hist.push_back(v);
        exp_p = hist[$] & ~hist[$-1];
        exp_n = ~hist[$] & hist[$-1];
        if (hist.size() > 4) void'(hist.pop_front());
      end
      check("pedge_rand", c, pedge_s, exp_p);
`ifdef EDGE_DETECTOR_NEG_EDGE_EN
      check("nedge_rand", c, nedge_s, exp_n);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
